// File: rtl/grayscale_pkg.sv
// Shared definitions for the grayscale stream converter: mode encodings,
// luma weights and the packed-pixel offset helper.
package grayscale_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_AVG    = 2'd1,
        MODE_LUMA   = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    localparam int LUMA_WR    = 77;
    localparam int LUMA_WG    = 150;
    localparam int LUMA_WB    = 29;
    localparam int LUMA_SHIFT = 8;

    // LSB position of pixel p in a packed word of w-bit channels.
    function automatic int pixel_lsb(input int p, input int w);
        return p * 3 * w;
    endfunction

endpackage

// File: rtl/grayscale_pixel.sv
// Per-pixel two-stage arithmetic: stage 1 registers channel sum and luma
// products, stage 2 selects and registers the converted pixel.
module grayscale_pixel
    import grayscale_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ld1_i,
    input  logic                       ld2_i,
    input  logic [3*CHANNEL_WIDTH-1:0] pix_i,
    input  mode_e                      mode_p1_i,
`ifdef GRAYSCALE_THRESHOLD_EN
    input  logic [CHANNEL_WIDTH-1:0]   thr_p1_i,
`endif
    output logic [3*CHANNEL_WIDTH-1:0] y_p2_o
);

    localparam int W  = CHANNEL_WIDTH;
    localparam int SW = W + 2;
    localparam int LW = W + 8;

    logic [W-1:0]    r, g, b;
    logic [SW-1:0]   sum_d, sum_p1_q;
    logic [LW-1:0]   luma_d, luma_p1_q;
    logic [3*W-1:0]  pix_p1_q;
    logic [W-1:0]    avg_w, luma_w;
    logic [3*W-1:0]  y_d, y_p2_q;

    assign r = pix_i[3*W-1:2*W];
    assign g = pix_i[2*W-1:W];
    assign b = pix_i[W-1:0];

    assign sum_d  = SW'(r) + SW'(g) + SW'(b);
    assign luma_d = LW'(LUMA_WR) * LW'(r) + LW'(LUMA_WG) * LW'(g) + LW'(LUMA_WB) * LW'(b);

    // Stage 1: raw pixel, channel sum and weighted luma sum
    always_ff @(posedge clock) begin
        if (ld1_i) begin
            pix_p1_q  <= pix_i;
            sum_p1_q  <= sum_d;
            luma_p1_q <= luma_d;
        end
    end

    // Weights total 256, so the shifted luma always fits in W bits.
    assign avg_w  = W'(sum_p1_q / SW'(3));
    assign luma_w = W'(luma_p1_q >> LUMA_SHIFT);

    always_comb begin
        y_d = pix_p1_q;
        case (mode_p1_i)
            MODE_AVG:    y_d = {3{avg_w}};
            MODE_LUMA:   y_d = {3{luma_w}};
`ifdef GRAYSCALE_THRESHOLD_EN
            MODE_THRESH: y_d = (luma_w >= thr_p1_i) ? '1 : '0;
`endif
            default:     y_d = pix_p1_q;
        endcase
    end

    // Stage 2: converted pixel, cleared by reset so the output word reads zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y_p2_q <= '0;
        end else if (ld2_i) begin
            y_p2_q <= y_d;
        end
    end

    assign y_p2_o = y_p2_q;

endmodule

// File: rtl/grayscale_stream.sv
// FIFO-to-FIFO grayscale converter with a 2-stage backpressured pipeline.
// Define GRAYSCALE_THRESHOLD_EN to enable mode 3 threshold; otherwise it is passthrough.
module grayscale_stream
    import grayscale_pkg::*;
#(
    parameter int CHANNEL_WIDTH   = 8,
    parameter int PIXELS          = 1,
    parameter int FIFO_DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [CHANNEL_WIDTH-1:0]   threshold,
    output logic                       fifo_in_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_in_dout,
    input  logic                       fifo_in_empty,
    output logic                       fifo_out_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_out_din,
    input  logic                       fifo_out_full,
    output logic [31:0]                word_count
);

    localparam int PW = PIXELS * 3 * CHANNEL_WIDTH;

    logic        v1_q, v1_d, v2_q, v2_d;
    logic        adv1, adv2, ld2;
    logic [31:0] word_count_q, word_count_d;
    mode_e       mode_p1_q;
    logic [PW-1:0] gray_word;

    assign adv2           = !v2_q || !fifo_out_full;
    assign adv1           = !v1_q || adv2;
    assign fifo_in_rd_en  = !fifo_in_empty && adv1;
    assign fifo_out_wr_en = v2_q && !fifo_out_full;
    assign ld2            = adv2 && v1_q;

    assign v1_d         = adv1 ? fifo_in_rd_en : v1_q;
    assign v2_d         = adv2 ? v1_q : v2_q;
    assign word_count_d = word_count_q + 32'(fifo_out_wr_en);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            word_count_q <= '0;
        end else begin
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            word_count_q <= word_count_d;
        end
    end

    // Stage 1 side-band: mode (and threshold) follow their word down the pipe
    always_ff @(posedge clock) begin
        if (fifo_in_rd_en) begin
            mode_p1_q <= mode_e'(mode);
        end
    end

`ifdef GRAYSCALE_THRESHOLD_EN
    logic [CHANNEL_WIDTH-1:0] thr_p1_q;

    always_ff @(posedge clock) begin
        if (fifo_in_rd_en) begin
            thr_p1_q <= threshold;
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^threshold;
`endif

    for (genvar p = 0; p < PIXELS; p++) begin : g_pix
        grayscale_pixel #(
            .CHANNEL_WIDTH(CHANNEL_WIDTH)
        ) u_pix (
            .clock     (clock),
            .reset     (reset),
            .ld1_i     (fifo_in_rd_en),
            .ld2_i     (ld2),
            .pix_i     (fifo_in_dout[pixel_lsb(p, CHANNEL_WIDTH) +: 3*CHANNEL_WIDTH]),
            .mode_p1_i (mode_p1_q),
`ifdef GRAYSCALE_THRESHOLD_EN
            .thr_p1_i  (thr_p1_q),
`endif
            .y_p2_o    (gray_word[pixel_lsb(p, CHANNEL_WIDTH) +: 3*CHANNEL_WIDTH])
        );
    end

    if (FIFO_DATA_WIDTH > PW) begin : g_pad
        logic unused_dout_hi;
        assign unused_dout_hi = ^fifo_in_dout[FIFO_DATA_WIDTH-1:PW];
    end

    assign fifo_out_din = FIFO_DATA_WIDTH'(gray_word);
    assign word_count   = word_count_q;

endmodule
